// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential word fetches to the
// instruction memory, buffers in-order responses and hands them to decode
// together with their PC. Redirects flush everything buffered and squash any
// responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  localparam logic [0:0] STATE_FETCH = 1'b0;
  localparam logic [0:0] STATE_FLUSH = 1'b1;

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] occ;
  logic [CW-1:0] drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];

  logic [CW:0]   in_use;
  logic          req_fire;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic [CW-1:0] drop_next;
  logic [31:0]   target_pc;

  // Request/response/pop qualification; rst gates the request so nothing is
  // offered to memory while reset is held.
  always_comb begin
    in_use         = {1'b0, occ} + {1'b0, outstanding};
    imem_req_valid = rst && (state == STATE_FETCH) && (in_use < CAP) && !redirect_valid;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (outstanding != '0);
    push           = rsp_take && (state == STATE_FETCH) && !redirect_valid;
    inst_valid     = (occ != '0);
    pop            = inst_valid && inst_ready;
    inst           = buf_data[rd_ptr];
    inst_pc        = buf_pc[rd_ptr];
    drop_next      = outstanding - CW'(rsp_take);
    target_pc      = redirect_pc & 32'hFFFF_FFFC;
  end

  // PC, response PC, in-flight count and flush bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= STATE_FETCH;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (redirect_valid) begin
        pc     <= target_pc;
        rsp_pc <= target_pc;
        drop   <= drop_next;
        state  <= (drop_next != '0) ? STATE_FLUSH : STATE_FETCH;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (state == STATE_FLUSH) begin
          if (rsp_take) begin
            drop <= drop - CW'(1);
          end
          if ((drop == '0) || (rsp_take && (drop == CW'(1)))) begin
            state <= STATE_FETCH;
          end
        end
      end
    end
  end

  // Instruction buffer: registered FIFO, cleared outright on a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= imem_rsp_data;
        buf_pc[wr_ptr]   <= rsp_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order instruction memory with
// configurable latency returns 0x13+addr for every fetch, and a queue-based
// reference model predicts the request stream and the delivered instructions.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int fire_count = 0;
  int mem_lat = 1;

  logic        d_req_ready = 1'b1;
  logic        d_inst_ready = 1'b1;
  logic        d_redirect = 1'b0;
  logic        d_force_rsp = 1'b0;
  logic [31:0] d_redirect_pc = '0;

  logic [31:0] mem_addr_q [$];
  int          mem_due_q  [$];

  logic [31:0] m_fifo_pc   [$];
  logic [31:0] m_fifo_data [$];
  logic [31:0] m_valid_pc  [$];
  int          m_stale;
  logic [31:0] m_pc;

  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_ipc;

  typedef struct {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl [12];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // One clock cycle: called just after a falling edge, returns after the next one.
  task automatic applyStimulus();
    logic        e_rv;
    logic        rsp_now;
    logic        pop_m;
    logic        rsp_m;
    logic [31:0] p;
    imem_req_ready = d_req_ready;
    inst_ready     = d_inst_ready;
    redirect_valid = d_redirect;
    redirect_pc    = d_redirect_pc;
    rsp_now = d_force_rsp || (mem_addr_q.size() > 0 && mem_due_q[0] <= cycle);
    imem_rsp_valid = rsp_now;
    if (!d_force_rsp && mem_addr_q.size() > 0) imem_rsp_data = mem_addr_q[0] + 32'h13;
    else imem_rsp_data = $urandom;
    #1;
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid; s_ipc = inst_pc;
    e_rv = !d_redirect && (m_stale == 0) && (m_fifo_pc.size() + m_valid_pc.size() < DEPTH);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(e_rv));
    checkOutput("req_addr", imem_req_addr, m_pc);
    checkOutput("inst_valid", 32'(inst_valid), 32'(m_fifo_pc.size() > 0));
    if (m_fifo_pc.size() > 0) begin
      checkOutput("inst", inst, m_fifo_data[0]);
      checkOutput("inst_pc", inst_pc, m_fifo_pc[0]);
    end
    if (rsp_now && !d_force_rsp) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (imem_req_valid && d_req_ready) begin
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cycle + mem_lat);
      fire_count++;
    end
    pop_m = (m_fifo_pc.size() > 0) && d_inst_ready;
    rsp_m = rsp_now && (m_stale + m_valid_pc.size() > 0);
    if (pop_m) begin
      void'(m_fifo_pc.pop_front());
      void'(m_fifo_data.pop_front());
    end
    if (rsp_m) begin
      if (m_stale > 0) m_stale--;
      else begin
        p = m_valid_pc.pop_front();
        if (!d_redirect) begin
          m_fifo_pc.push_back(p);
          m_fifo_data.push_back(p + 32'h13);
        end
      end
    end
    if (e_rv && d_req_ready) begin
      m_valid_pc.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (d_redirect) begin
      m_fifo_pc.delete();
      m_fifo_data.delete();
      m_stale += m_valid_pc.size();
      m_valid_pc.delete();
      m_pc = d_redirect_pc & 32'hFFFF_FFFC;
    end
    d_force_rsp = 1'b0;
    d_redirect  = 1'b0;
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  // Asynchronous reset taken mid-cycle; outputs are checked before any clock edge.
  task automatic doReset();
    #2;
    rst = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    mem_addr_q.delete(); mem_due_q.delete();
    m_fifo_pc.delete(); m_fifo_data.delete(); m_valid_pc.delete();
    m_stale = 0; m_pc = RESET_PC;
    d_redirect = 1'b0; d_force_rsp = 1'b0;
    #1;
    checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("reset_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_inst_pc", inst_pc, 32'd0);
    checkOutput("reset_req_addr", imem_req_addr, RESET_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        seen;
    logic [31:0] exp_pcs [3];
    int          got_n;

    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[6]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
    tbl[7]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
    tbl[8]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[9]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[10] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[11] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    // Reset release into a 1-cycle memory, with a short decode stall.
    doReset();
    mem_lat = 1; d_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d_inst_ready = tbl[i].ir;
      applyStimulus();
      checkOutput("tbl_req_valid", 32'(s_rv), 32'(tbl[i].rv));
      checkOutput("tbl_req_addr", s_addr, tbl[i].addr);
      checkOutput("tbl_inst_valid", 32'(s_iv), 32'(tbl[i].iv));
      if (tbl[i].iv) checkOutput("tbl_inst_pc", s_ipc, tbl[i].ipc);
    end

    // Decode stalled from empty: the buffer+in-flight cap stops fetching at DEPTH.
    doReset();
    d_inst_ready = 1'b0; fire_count = 0;
    repeat (10) applyStimulus();
    checkOutput("stall_fires", 32'(fire_count), 32'(DEPTH));
    checkOutput("stall_req_valid", 32'(s_rv), 32'd0);
    checkOutput("stall_inst_valid", 32'(s_iv), 32'd1);
    d_inst_ready = 1'b1;
    repeat (8) applyStimulus();

    // Memory backpressure at 0x8: address holds until accepted.
    doReset();
    d_inst_ready = 1'b1;
    repeat (2) applyStimulus();
    d_req_ready = 1'b0;
    repeat (3) begin
      applyStimulus();
      checkOutput("hold_addr", s_addr, 32'h8);
      checkOutput("hold_valid", 32'(s_rv), 32'd1);
    end
    d_req_ready = 1'b1;
    applyStimulus();
    checkOutput("hold_accept_addr", s_addr, 32'h8);
    applyStimulus();
    checkOutput("hold_next_addr", s_addr, 32'hC);

    // Redirect with two fetches in flight on a 3-cycle memory.
    doReset();
    mem_lat = 3;
    repeat (2) applyStimulus();
    d_redirect = 1'b1; d_redirect_pc = 32'h100;
    applyStimulus();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus();
      if (s_iv) begin
        seen = 1'b1;
        checkOutput("flush_first_pc", s_ipc, 32'h100);
      end
    end
    if (!seen) checkOutput("flush_timeout", 32'd0, 32'd1);

    // Redirect coinciding with a response and a pop; low address bits ignored.
    doReset();
    mem_lat = 1;
    repeat (5) applyStimulus();
    d_redirect = 1'b1; d_redirect_pc = 32'h203;
    applyStimulus();
    applyStimulus();
    checkOutput("redir_inst_valid", 32'(s_iv), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      applyStimulus();
      if (s_iv) begin
        seen = 1'b1;
        checkOutput("redir_first_pc", s_ipc, 32'h200);
      end
    end
    if (!seen) checkOutput("redir_timeout", 32'd0, 32'd1);

    // Redirect near the top of the address space: PC wraps to zero.
    d_redirect = 1'b1; d_redirect_pc = 32'hFFFF_FFF8;
    applyStimulus();
    exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC; exp_pcs[2] = 32'h0000_0000;
    got_n = 0;
    for (int i = 0; i < 30 && got_n < 3; i++) begin
      applyStimulus();
      if (s_iv) begin
        checkOutput("wrap_pc", s_ipc, exp_pcs[got_n]);
        got_n++;
      end
    end
    if (got_n < 3) checkOutput("wrap_timeout", 32'(got_n), 32'd3);

    // Randomised traffic; the first cycle carries a stray response that must be ignored.
    doReset();
    d_force_rsp = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      d_req_ready  = ($urandom_range(0, 3) != 0);
      d_inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        d_redirect = 1'b1;
        d_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
      end
      applyStimulus();
    end

    // Reset asserted mid-stream, then normal operation resumes.
    doReset();
    d_req_ready = 1'b1; d_inst_ready = 1'b1; mem_lat = 2;
    repeat (8) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that drives the instruction memory and feeds decode, which includes the immediate sign-extender and the control block.
- Holds the PC and issues sequential word fetches over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents each instruction with its PC.
- Supports redirects from branch resolution, which flush all buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, instruction buffer entries; also the cap on (buffered + outstanding) fetches. Power of 2, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch byte address, word aligned.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid. Responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode consumes inst.
- redirect_valid  in  1  redirect request, single-cycle pulse.
- redirect_pc  in  32  new fetch PC. Bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, rsp_pc=RESET_PC; FIFO empty; outstanding=0; state=FETCH.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, imem_req_addr=RESET_PC.
- Registers:
  - pc is the next request address; imem_req_addr=pc.
  - rsp_pc is the PC of the next response to arrive.
  - outstanding counts accepted but unanswered requests, range 0..DEPTH.
  - occ is FIFO occupancy, range 0..DEPTH.
- States: FETCH and FLUSH.
- imem_req_valid = (state==FETCH) and (occ+outstanding < DEPTH) and not redirect_valid.
  - Uses current-cycle values only, with no credit for a same-cycle pop.
- While imem_req_valid=1 and imem_req_ready=0, imem_req_addr holds stable.
- Request handshake: pc<=pc+4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); outstanding++.
- Response in FETCH (imem_rsp_valid=1 and outstanding>0):
  - Push {imem_rsp_data, rsp_pc} into the FIFO.
  - rsp_pc<=rsp_pc+4, with the same wrap; outstanding--.
- imem_rsp_valid with outstanding==0 is ignored and must not underflow.
- Output timing:
  - FIFO is registered: a response in cycle N gives inst_valid=1 no earlier than cycle N+1.
  - inst/inst_pc come from the FIFO head; inst_valid=(occ>0).
  - Pop on inst_valid and inst_ready.
  - Push and pop in the same cycle leave occ unchanged.
- Redirect (any state, cycle R):
  - FIFO cleared; inst_valid=0 from R+1.
  - pc<=redirect_pc, rsp_pc<=redirect_pc.
  - A same-cycle pop is still a completed handshake; decode owns the squash.
  - A same-cycle response is dropped.
  - No request is issued in cycle R.
  - drop <= outstanding, less 1 if a response arrived in R.
  - Next state: FLUSH if drop>0, else FETCH.
- FLUSH:
  - No requests are issued.
  - Each response decrements drop and is discarded.
  - Go to FETCH in the cycle after drop reaches 0.
  - A redirect in FLUSH updates pc/rsp_pc and recomputes drop as above.
- Throughput: with DEPTH=4, 1-cycle memory latency and inst_ready=1, sustains 1 instruction/cycle after a 2-cycle warm-up.
- Backpressure: with inst_ready=0, requests stop once occ+outstanding==DEPTH. No response is ever lost; in-flight responses always have a free slot.
- Reset mid-operation: all state is cleared immediately; stale responses are ignored via the outstanding==0 rule.

Test Plan:
- Reset release, 1-cycle memory returning 0x00000013+addr, inst_ready=1 -> requests at 0x0,0x4,0x8,...; inst_pc 0x0 on the 3rd cycle after reset, then one instruction per cycle, with inst matching the addr encoding.
- inst_ready=0 for 10 cycles -> exactly 4 requests issued, occ=4, imem_req_valid=0. Then ready=1 -> 4 instructions in order with no gaps or duplicates, and fetching resumes.
- imem_req_ready low for 3 cycles at addr 0x8 -> imem_req_addr stays 0x8 for all 3 cycles; pc advances only after the handshake.
- 3-cycle memory latency with 2 outstanding, redirect_pc=0x100 -> both stale responses are discarded in FLUSH; the first delivered inst_pc is 0x100; no inst_valid between the redirect and the 0x100 delivery.
- Redirect in the same cycle as a response and a pop; redirect_pc=0x203 -> response dropped, next inst_pc is 0x200, occ goes to 0.
- Redirect to 0xFFFF_FFF8 -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst low mid-stream -> outputs return to reset values asynchronously.
